// File: rtl/trig_cordic_unit_if.sv
// rtl/trig_cordic_unit_if.sv - trig request/response bundle between decode/execute and the CORDIC unit
interface trig_cordic_unit_if #(
    parameter int DATA_W = 16
);
    logic              start;
    logic              func;
    logic [DATA_W-1:0] angle;
    logic [DATA_W-1:0] result;
    logic              done;
    logic              busy;
    logic              stall;

    modport master (
        output start, func, angle,
        input  result, done, busy, stall
    );

    modport slave (
        input  start, func, angle,
        output result, done, busy, stall
    );
endinterface

// File: rtl/trig_cordic_unit.sv
// rtl/trig_cordic_unit.sv - iterative CORDIC sine/cosine unit with pipeline stall request
// One micro-rotation per cycle; result saturated to +/-1.0 in Q2.14.
module trig_cordic_unit #(
    parameter int DATA_W = 16,
    parameter int ITER   = 14,
    parameter int GUARD  = 2
) (
    input  logic            clk,
    input  logic            rst,
    trig_cordic_unit_if.slave io
);
    localparam int W = DATA_W + GUARD;

    localparam logic signed [DATA_W-1:0] ANG_MAX = DATA_W'(16'sh6488);
    localparam logic signed [DATA_W-1:0] ANG_MIN = -ANG_MAX;
    localparam logic signed [W-1:0]      K_INIT  = W'(16'sh26DD) <<< GUARD;
    localparam logic signed [W-1:0]      POS_ONE = W'(16'sh4000);
    localparam logic signed [W-1:0]      NEG_ONE = -POS_ONE;
    localparam logic [3:0]               I_LAST  = 4'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state_q;
    logic signed [W-1:0]       x_q, y_q, z_q;
    logic signed [W-1:0]       x_d, y_d, z_d;
    logic [3:0]                i_q;
    logic                      func_q;
    logic [DATA_W-1:0]         result_q;
    logic                      done_q;
    logic                      busy_q;

    logic signed [DATA_W-1:0]  ang;
    logic signed [DATA_W-1:0]  ang_cl;
    logic signed [W-1:0]       z_ld;
    logic signed [W-1:0]       res_sel;
    logic signed [W-1:0]       res_full;
    logic [DATA_W-1:0]         res_sat;

    // atan(2^-i) in Q2.14, widened onto the guard-extended z grid
    function automatic logic signed [W-1:0] atan_lut(input logic [3:0] idx);
        logic [DATA_W-1:0] v;
        case (idx)
            4'd0:    v = 16'h3244;
            4'd1:    v = 16'h1DAC;
            4'd2:    v = 16'h0FAE;
            4'd3:    v = 16'h07F5;
            4'd4:    v = 16'h03FF;
            4'd5:    v = 16'h0200;
            4'd6:    v = 16'h0100;
            4'd7:    v = 16'h0080;
            4'd8:    v = 16'h0040;
            4'd9:    v = 16'h0020;
            4'd10:   v = 16'h0010;
            4'd11:   v = 16'h0008;
            4'd12:   v = 16'h0004;
            4'd13:   v = 16'h0002;
            4'd14:   v = 16'h0001;
            default: v = 16'h0000;
        endcase
        return W'(v) <<< GUARD;
    endfunction

    always_comb begin
        ang    = $signed(io.angle);
        ang_cl = ang;
        if (ang > ANG_MAX) begin
            ang_cl = ANG_MAX;
        end else if (ang < ANG_MIN) begin
            ang_cl = ANG_MIN;
        end
        z_ld = W'(ang_cl) <<< GUARD;
    end

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        z_d = z_q;
        if (z_q >= 0) begin
            x_d = x_q - (y_q >>> i_q);
            y_d = y_q + (x_q >>> i_q);
            z_d = z_q - atan_lut(i_q);
        end else begin
            x_d = x_q + (y_q >>> i_q);
            y_d = y_q - (x_q >>> i_q);
            z_d = z_q + atan_lut(i_q);
        end
    end

    // Final rotation result drops the guard bits, then clips to exactly +/-1.0
    always_comb begin
        res_sel  = func_q ? x_d : y_d;
        res_full = res_sel >>> GUARD;
        if (res_full > POS_ONE) begin
            res_sat = POS_ONE[DATA_W-1:0];
        end else if (res_full < NEG_ONE) begin
            res_sat = NEG_ONE[DATA_W-1:0];
        end else begin
            res_sat = res_full[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            z_q      <= '0;
            i_q      <= '0;
            func_q   <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (io.start) begin
                        x_q     <= K_INIT;
                        y_q     <= '0;
                        z_q     <= z_ld;
                        i_q     <= '0;
                        func_q  <= io.func;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    x_q <= x_d;
                    y_q <= y_d;
                    z_q <= z_d;
                    i_q <= i_q + 4'd1;
                    if (i_q == I_LAST) begin
                        result_q <= res_sat;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Combinational on start so the issuing instruction freezes in its own cycle
    assign io.stall  = !rst && ((state_q == RUN) || ((state_q == IDLE) && io.start));
    assign io.result = result_q;
    assign io.done   = done_q;
    assign io.busy   = busy_q;
endmodule

// File: tb/tb_trig_cordic_unit.sv
// tb/tb_trig_cordic_unit.sv - scoreboard bench for trig_cordic_unit with directed angle vectors
module tb_trig_cordic_unit;
    localparam int DATA_W = 16;
    localparam int ITER   = 14;
    localparam int GUARD  = 2;
    localparam int LAT    = ITER + 1;

    typedef struct {
        int    lo;
        int    hi;
        int    cyc;
        string name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    trig_cordic_unit_if #(.DATA_W(DATA_W)) bus ();

    trig_cordic_unit #(
        .DATA_W(DATA_W),
        .ITER  (ITER),
        .GUARD (GUARD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io (bus)
    );

    exp_t sb[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_fail = 0;
    logic stall_hist [0:1023];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < 1024) stall_hist[cyc] = bus.stall;
    end

    always @(negedge clk) begin
        if (bus.done === 1'b1) begin : mon
            exp_t e;
            int   r;
            r = int'($signed(bus.result));
            n_vec++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: cycle %0d result 0x%h, no operation outstanding", cyc, bus.result);
            end else begin
                e = sb.pop_front();
                if (r < e.lo || r > e.hi) begin
                    n_fail++;
                    $display("FAIL %s_result: got %0d (0x%h), required %0d..%0d", e.name, r, bus.result, e.lo, e.hi);
                end
                n_vec++;
                if (cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL %s_latency: done at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, required 0x%h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] ang, input logic f, input int lo, input int hi, input string name);
        bus.start = 1'b1;
        bus.angle = ang;
        bus.func  = f;
        sb.push_back('{lo, hi, cyc + LAT, name});
        wait_cycles(1);
        bus.start = 1'b0;
    endtask

    task automatic poke(input logic [15:0] ang, input logic f);
        bus.start = 1'b1;
        bus.angle = ang;
        bus.func  = f;
        wait_cycles(1);
        bus.start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n0;
        logic [16:0] win;

        bus.start = 1'b1;
        bus.func  = 1'b0;
        bus.angle = '0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_result", 32'(bus.result), 32'h0);
        check("rst_done",   32'(bus.done),   32'h0);
        check("rst_busy",   32'(bus.busy),   32'h0);
        check("rst_stall",  32'(bus.stall),  32'h0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        wait_cycles(1);

        n0 = cyc;
        issue(16'h0000, 1'b0, -3, 3, "sin_0");
        wait_cycles(15);
        for (int k = 0; k < 17; k++) win[k] = stall_hist[n0 - 1 + k];
        check("stall_window", 32'(win), 32'h0FFFE);

        issue(16'h0000, 1'b1, 16'h4000 - 3, 16'h4000, "cos_0");
        wait_cycles(15);
        issue(16'h2182, 1'b0, 16'h2000 - 3, 16'h2000 + 3, "sin_pi6");
        wait_cycles(15);
        issue(16'h4305, 1'b1, 16'h2000 - 3, 16'h2000 + 3, "cos_pi3");
        wait_cycles(15);
        issue(16'h9B78, 1'b0, -16'sh4000, -16'sh4000 + 3, "sin_mpi2");
        wait_cycles(15);
        issue(16'h7FFF, 1'b0, 16'h4000 - 3, 16'h4000, "sin_clamp_pos");
        wait_cycles(15);
        issue(16'h8000, 1'b1, -3, 3, "cos_clamp_neg");
        wait_cycles(15);

        // re-pulsed start at cycle 5 must not restart or relatch
        issue(16'h2182, 1'b0, 16'h2000 - 3, 16'h2000 + 3, "ignore_busy");
        wait_cycles(4);
        poke(16'h0000, 1'b1);
        wait_cycles(12);

        // start during DONE ignored, start in the following cycle accepted
        issue(16'h4305, 1'b1, 16'h2000 - 3, 16'h2000 + 3, "b2b_first");
        wait_cycles(14);
        poke(16'h0000, 1'b1);
        issue(16'h9B78, 1'b0, -16'sh4000, -16'sh4000 + 3, "b2b_second");
        wait_cycles(16);

        // reset in cycle 7 of RUN aborts without a done pulse
        poke(16'h2182, 1'b0);
        wait_cycles(6);
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy",   32'(bus.busy),   32'h0);
        check("midrst_result", 32'(bus.result), 32'h0);
        check("midrst_done",   32'(bus.done),   32'h0);
        check("midrst_stall",  32'(bus.stall),  32'h0);
        wait_cycles(20);
        issue(16'h0000, 1'b1, 16'h4000 - 3, 16'h4000, "after_rst");
        wait_cycles(20);

        check("pending_ops", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/trig_cordic_unit.md
# trig_cordic_unit

Iterative CORDIC sine/cosine unit in the execute stage. It consumes the decode→execute trig control bit (`trigControl`) together with the SIN/COS selection and the angle operand. It produces a Q2.14 result for the memory/writeback path. While it computes, it asserts a stall toward the hazard logic so the pipeline freezes until the result is ready.

## Interface
- `DATA_W`, 16: operand/result width. Q2.14 signed fixed point, so 1.0 = 0x4000.
- `ITER`, 14: CORDIC iterations. Legal range is 8..16.
- `GUARD`, 2: extra internal LSB-side bits added to x/y/z datapath width.

Ports (clock and reset first):
- `clk`  in  1  pipeline clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  `trigControl` from the decode/execute register, qualified by a valid instruction.
- `func`  in  1  0 = SIN, 1 = COS. Derived from cmd SIN (5'b01010) / COS (5'b01011) LSB.
- `angle`  in  DATA_W  signed Q2.14 radians.
- `result`  out  DATA_W  signed Q2.14 sin/cos value.
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `busy`  out  1  high in RUN and DONE.
- `stall`  out  1  freeze request to the hazard unit.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN when `start`=1.
  - RUN→DONE after iteration index `i` = ITER-1 completes.
  - DONE→IDLE unconditionally.
- Capture in IDLE on `start`:
  - Clamp `angle` to [-0x6488, +0x6488] (±π/2).
  - Load x = K = 0x26DD (0.60725), y = 0, z = clamped angle, i = 0.
  - Latch `func`.
- RUN, one micro-rotation per cycle:
  - d = +1 if z ≥ 0, else −1.
  - x ← x − d·(y >>> i); y ← y + d·(x >>> i); z ← z − d·atan_lut[i]. All updates are simultaneous, using old x/y.
  - `>>>` is arithmetic shift. Internal width is DATA_W+GUARD. Results are truncated back to DATA_W when driving the output.
- atan_lut: 16-entry constant ROM, atan(2^-i) in Q2.14, scaled by 2^GUARD internally.
  - Entries 0..3: 0x3244, 0x1DAC, 0x0FAE, 0x07F5.
  - Remaining entries are computed the same way, rounded to nearest.
- DONE:
  - `result` = func ? x : y, saturated to [-0x4000, +0x4000].
  - `done` = 1 for this cycle only.
- `result` holds its value after DONE until the next DONE or reset.
- `start` while busy is ignored. The pipeline is stalled, so upstream must re-present the instruction; it does.
- `stall` = (state==RUN) | (state==IDLE & `start`). It is combinational on `start` so the issuing instruction freezes in its first cycle.
- `stall` is 0 in DONE, so the pipeline advances in the same cycle `result` is valid.

## Timing
- Reset, and any cycle with `rst`=1 (including mid-RUN):
  - State → IDLE; `result`=0, `done`=0, `busy`=0; x/y/z/i cleared.
  - `stall` output follows `start` only after `rst` deasserts. While `rst`=1, `stall`=0.
- Latency:
  - `start` sampled at edge 0.
  - RUN occupies cycles 1..ITER.
  - `done` is high in cycle ITER+1, i.e. 15 cycles for the default.
- `stall` is high for exactly ITER+1 cycles per operation (cycle 0 through cycle ITER).
- Back-to-back: a new `start` is accepted in the cycle after DONE (IDLE). `start` asserted during DONE is ignored.
- Accuracy: |error| ≤ 3 LSB versus ideal over the clamped range for ITER=14.

## Test plan
- Reset values: assert `rst` 2 cycles → `result`=0, `done`=0, `busy`=0, `stall`=0.
- Basic SIN and latency: angle=0x0000, func=0, start pulse → `done` exactly 15 cycles later, `result`=0x0000 ±2; repeat with func=1 → 0x4000 ±2.
- Reference angles:
  - 0x2182 (π/6) SIN → 0x2000 ±3.
  - 0x4305 (π/3) COS → 0x2000 ±3.
  - 0x9B78 (−π/2) SIN → 0xC000 ±3.
- Clamp and saturation: angle=0x7FFF SIN → clamped to π/2, `result`=0x4000 exactly (saturated, never above 0x4000).
- Handshake:
  - `stall` high for 15 consecutive cycles starting with the start cycle, then low in the `done` cycle.
  - `start` re-pulsed at cycle 5 → ignored, single `done`.
  - `start` in the cycle after `done` → second op completes 15 cycles later.
- Reset mid-op: `rst` at cycle 7 of RUN → next cycle IDLE, `busy`=0, `result`=0, no `done` pulse; a following start completes normally.
